// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch/memory-interface stage and the
// blocks that reuse its decoder.
//   - mem_cmd encodings (MEM_NONE / MEM_READ / MEM_WRITE; 2'b11 acts as NONE)
//   - one-hot nsel constants selecting Rn / Rd / Rm
//   - bit positions of the fields inside the 16-bit instruction word
//   - the bus handshake state enum
package cpu_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  // Least significant bit of each multi-bit instruction field
  localparam int IR_OPCODE_LSB = 13;
  localparam int IR_OP_LSB     = 11;
  localparam int IR_RN_LSB     = 8;
  localparam int IR_RD_LSB     = 5;
  localparam int IR_SHIFT_LSB  = 3;
  localparam int IR_RM_LSB     = 0;
  // Sign bits of the two immediates
  localparam int IR_IMM5_MSB   = 4;
  localparam int IR_IMM8_MSB   = 7;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_BUSY = 2'd1,
    BUS_DONE = 2'd2
  } bus_state_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational split of the instruction register into
// the fields consumed by the control FSM and the datapath, plus the nsel
// register-number mux.
// Ports:
//   i_ir        instruction word
//   i_nsel      one-hot register select (100 Rn, 010 Rd, 001 Rm)
//   o_opcode    IR[15:13]
//   o_op        IR[12:11]
//   o_aluOp     IR[12:11] (same bits, separate consumer)
//   o_shift     IR[4:3]
//   o_readnum   register chosen by i_nsel, 0 when i_nsel is not one-hot
//   o_writenum  same as o_readnum
//   o_sximm5    IR[4:0] sign-extended to DATA_W
//   o_sximm8    IR[7:0] sign-extended to DATA_W
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_ir,
  input  logic [2:0]        i_nsel,
  output logic [2:0]        o_opcode,
  output logic [1:0]        o_op,
  output logic [1:0]        o_aluOp,
  output logic [1:0]        o_shift,
  output logic [2:0]        o_readnum,
  output logic [2:0]        o_writenum,
  output logic [DATA_W-1:0] o_sximm5,
  output logic [DATA_W-1:0] o_sximm8
);

  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;
  logic [2:0] w_sel;

  assign o_opcode = i_ir[IR_OPCODE_LSB +: 3];
  assign o_op     = i_ir[IR_OP_LSB +: 2];
  assign o_aluOp  = i_ir[IR_OP_LSB +: 2];
  assign o_shift  = i_ir[IR_SHIFT_LSB +: 2];

  assign w_rn = i_ir[IR_RN_LSB +: 3];
  assign w_rd = i_ir[IR_RD_LSB +: 3];
  assign w_rm = i_ir[IR_RM_LSB +: 3];

  assign o_sximm5 = {{(DATA_W-IR_IMM5_MSB-1){i_ir[IR_IMM5_MSB]}}, i_ir[IR_IMM5_MSB:0]};
  assign o_sximm8 = {{(DATA_W-IR_IMM8_MSB-1){i_ir[IR_IMM8_MSB]}}, i_ir[IR_IMM8_MSB:0]};

  // Register-number mux; anything other than a clean one-hot select picks R0
  always_comb begin
    w_sel = 3'd0;
    case (i_nsel)
      NSEL_RN: w_sel = w_rn;
      NSEL_RD: w_sel = w_rd;
      NSEL_RM: w_sel = w_rm;
      default: w_sel = 3'd0;
    endcase
  end

  assign o_readnum  = w_sel;
  assign o_writenum = w_sel;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch and memory-interface stage. Holds PC, the
// data-address register DA and the instruction register IR, runs a
// request/ready handshake with a variable-latency memory and raises stall
// while an access is in flight so the control FSM holds its state.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   load_pc, reset_pc          PC increment / clear (clear needs load_pc too)
//   load_ir, load_addr         IR <- read buffer, DA <- datapath_out
//   addr_sel                   access address source: 1 = PC, 0 = DA
//   mem_cmd                    00 none, 01 read, 10 write, 11 none
//   nsel                       one-hot register select for readnum/writenum
//   datapath_out               DA source and write data
//   mem_rdata, mem_ready       memory response
//   mem_addr, mem_wdata        address / write data, frozen for the access
//   mem_read, mem_write        strobes, high for the whole access
//   stall                      access in flight
//   pc                         program counter
//   opcode, op, ALUop, shift   decoded IR fields
//   readnum, writenum          register number chosen by nsel
//   sximm5, sximm8             sign-extended immediates
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_ir,
  input  logic              load_addr,
  input  logic              addr_sel,
  input  logic [1:0]        mem_cmd,
  input  logic [2:0]        nsel,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  bus_state_t r_state;
  bus_state_t w_nextState;

  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_da;
  logic [PC_W-1:0]   r_addr;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_rdBuf;
  logic [DATA_W-1:0] r_wdata;
  logic              r_isWrite;

  logic w_cmdValid;
  logic w_cmdIsWrite;
  logic w_launch;
  logic w_stall;

  // 2'b11 is deliberately not a valid command, so it behaves like NONE
  assign w_cmdValid   = (mem_cmd == MEM_READ) || (mem_cmd == MEM_WRITE);
  assign w_cmdIsWrite = (mem_cmd == MEM_WRITE);

  // Bus state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BUS_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and Moore outputs. The strobes and stall decode only the state
  // register, so they come straight out of flops and drop the instant reset
  // is asserted. DONE only relaunches when the command changes; holding the
  // completed command keeps the FSM parked so it is not repeated.
  always_comb begin
    w_nextState = r_state;
    w_launch    = 1'b0;
    w_stall     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (w_cmdValid) begin
          w_nextState = BUS_BUSY;
          w_launch    = 1'b1;
        end
      end
      BUS_BUSY: begin
        w_stall   = 1'b1;
        mem_read  = !r_isWrite;
        mem_write = r_isWrite;
        if (mem_ready) begin
          w_nextState = BUS_DONE;
        end
      end
      BUS_DONE: begin
        if (!w_cmdValid) begin
          w_nextState = BUS_IDLE;
        end else if (w_cmdIsWrite != r_isWrite) begin
          w_nextState = BUS_BUSY;
          w_launch    = 1'b1;
        end
      end
      default: begin
        w_nextState = BUS_IDLE;
      end
    endcase
  end

  // Access capture at launch and read-data capture on completion. Launch
  // samples the PC/DA values from before any update at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_isWrite <= 1'b0;
      r_rdBuf   <= '0;
    end else begin
      if (w_launch) begin
        r_addr    <= addr_sel ? r_pc : r_da;
        r_wdata   <= datapath_out;
        r_isWrite <= w_cmdIsWrite;
      end
      if ((r_state == BUS_BUSY) && mem_ready && !r_isWrite) begin
        r_rdBuf <= mem_rdata;
      end
    end
  end

  // Architectural registers; all FSM load requests are ignored while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
      r_da <= '0;
      r_ir <= '0;
    end else if (!w_stall) begin
      if (load_pc) begin
        r_pc <= reset_pc ? '0 : r_pc + PC_W'(1);
      end
      if (load_addr) begin
        r_da <= datapath_out[PC_W-1:0];
      end
      if (load_ir) begin
        r_ir <= r_rdBuf;
      end
    end
  end

  assign stall     = w_stall;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign pc        = r_pc;

  instr_decoder #(
    .DATA_W(DATA_W)
  ) u_decoder (
    .i_ir      (r_ir),
    .i_nsel    (nsel),
    .o_opcode  (opcode),
    .o_op      (op),
    .o_aluOp   (ALUop),
    .o_shift   (shift),
    .o_readnum (readnum),
    .o_writenum(writenum),
    .o_sximm5  (sximm5),
    .o_sximm8  (sximm8)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and memory-interface stage sitting between the control FSM and instruction/data memory. It holds the program counter (PC), data-address register (DA) and instruction register (IR). It runs a request/ready bus handshake with a variable-latency memory and raises `stall` to hold the FSM. It also decodes IR into the `opcode`/`op` fields the FSM consumes and the register/immediate fields the datapath consumes.

## Interface
- `PC_W`, 9, PC/DA/memory address width
- `DATA_W`, 16, instruction/data word width
- `clk` in 1: rising-edge clock
- `reset` in 1: **asynchronous, active-low**; 0 resets all state
- `load_pc`, `reset_pc`, `load_ir`, `load_addr`, `addr_sel` in 1 each: FSM controls
- `mem_cmd` in 2: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
- `nsel` in 3: one-hot register select (100 Rn, 010 Rd, 001 Rm)
- `datapath_out` in DATA_W: source for DA and write data
- `mem_rdata` in DATA_W; `mem_ready` in 1: memory response
- `mem_addr` out PC_W; `mem_read`, `mem_write` out 1; `mem_wdata` out DATA_W
- `stall` out 1: access in flight; FSM must hold its state
- `pc` out PC_W
- `opcode` out 3; `op` out 2; `ALUop` out 2; `shift` out 2
- `readnum`, `writenum` out 3; `sximm5`, `sximm8` out DATA_W

## Operation
- Bus FSM has three states:
  - IDLE: no access.
  - BUSY: access launched; `mem_read`/`mem_write` asserted; `stall`=1.
  - DONE: access complete; `stall`=0.
- IDLE → BUSY when `mem_cmd` is READ or WRITE. At launch, capture:
  - address: PC if `addr_sel`=1, else DA
  - write data: `datapath_out`
  - command
- `mem_addr`, `mem_wdata` and the strobe stay constant for the whole of BUSY.
- BUSY → DONE on `mem_ready`=1. On a read, `rd_buf` ← `mem_rdata`. A write leaves `rd_buf` unchanged.
- DONE behaviour:
  - `mem_cmd` equal to the completed command: stay in DONE, no new access.
  - NONE: go to IDLE.
  - the other command: launch again, go to BUSY.
- `mem_ready` in IDLE or DONE is ignored.
- `mem_cmd` changes during BUSY are ignored.
- Control gating: while `stall`=1, `load_pc`, `load_ir` and `load_addr` have no effect.
- PC update, in priority order:
  - `reset_pc`&`load_pc`: PC ← 0
  - `load_pc`: PC ← PC+1, modulo 2^PC_W (511 → 0)
- `load_addr`: DA ← `datapath_out[PC_W-1:0]`.
- `load_ir`: IR ← `rd_buf`.
- Decode is combinational from IR:
  - `opcode`=IR[15:13]; `op`=`ALUop`=IR[12:11]
  - Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0]; `shift`=IR[4:3]
  - `sximm8` = sign-extend IR[7:0]; `sximm5` = sign-extend IR[4:0]
- `readnum` = `writenum` = register selected by `nsel`. Any non-one-hot `nsel` gives 0.

## Timing
- Reset (`reset`=0) clears, asynchronously:
  - PC, DA, IR and `rd_buf` to 0
  - bus state to IDLE
  - `mem_read`, `mem_write` and `stall` to 0; `mem_addr` to 0; `mem_wdata` to 0
- Reset during BUSY abandons the access. The strobe drops immediately, without waiting for a clock edge.
- Launch: a command seen at edge N puts the strobe and `stall` high from after edge N. `stall` is a registered output.
- Zero-wait memory: `mem_ready` high in the first BUSY cycle gives DONE after edge N+1. Minimum access is 1 cycle of `stall`.
- Wait states: each cycle with `mem_ready`=0 in BUSY adds one stall cycle. There is no timeout.
- `rd_buf` is valid from the cycle after `mem_ready`. A `load_ir` in that cycle captures it at the next edge. Decode outputs follow one edge later.
- PC/DA updates take effect at the edge. An access launched at the same edge uses the pre-update PC/DA.

## Structure
- Shared package `cpu_pkg` holds:
  - `mem_cmd` encodings (MEM_NONE, MEM_READ, MEM_WRITE)
  - `nsel` one-hot constants
  - IR field bit positions
  - bus-state enum
- One sub-module, `instr_decoder`: the combinational IR → fields logic plus the `nsel` mux. It is reused by later multi-cycle control revisions.

## Test plan
- Reset, then READ with `addr_sel`=1 and `mem_ready` delayed 3 cycles, `mem_rdata`=16'hD205 → expect:
  - `mem_addr`=0 held 3 cycles, `stall`=1 for 3 cycles
  - after `load_ir`: `opcode`=110, `op`=10, Rn=2, `sximm8`=16'h0005
- PC at 9'h1FF, `load_pc` → `pc`=0. Then `reset_pc`&`load_pc` from 5 → 0.
- `load_addr` with `datapath_out`=16'h0123, WRITE with `addr_sel`=0 → `mem_addr`=9'h123, `mem_wdata`=16'h0123, `mem_write` held until `mem_ready`, `rd_buf` unchanged.
- `load_pc` and `load_ir` asserted while `stall`=1 → PC and IR unchanged. The same requests after DONE take effect.
- `reset`=0 mid-BUSY → `mem_read` low before the next edge, bus IDLE. A late `mem_ready` is ignored.
- IR=16'hA8FF: `sximm8`=16'hFFFF, `sximm5`=16'hFFFF (IR[4:0]=5'h1F), `shift`=11 → `nsel` 100/010/001/011 → `readnum` 0/7/7/0.
